// File: rtl/cubic_sched.sv
// Round-robin scheduler sharing one pipelined cubic_fixed datapath among NREQ requesters.
// Optional CUBIC_SCHED_STATS_EN adds stat_issued / stat_stall counters.
module cubic_sched #(
   parameter int WID   = 16,
   parameter int FBITS = 12,
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*WID-1:0] req_x,
   input  logic [NREQ*WID-1:0] req_a0,
   input  logic [NREQ*WID-1:0] req_a1,
   input  logic [NREQ*WID-1:0] req_a2,
   output logic [WID-1:0]      cub_x,
   output logic [WID-1:0]      cub_a0,
   output logic [WID-1:0]      cub_a1,
   output logic [WID-1:0]      cub_a2,
   input  logic [WID-1:0]      cub_y,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [WID-1:0]      res_y,
   output logic [IDW-1:0]      res_id
`ifdef CUBIC_SCHED_STATS_EN
   ,
   output logic [31:0]         stat_issued,
   output logic [31:0]         stat_stall
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(DEPTH + LAT + 2);

   if (NREQ < 2 || NREQ > 8 || LAT < 1 || DEPTH < 1 || FBITS < 0 || FBITS >= WID) begin : g_bad_cfg
      $error("cubic_sched: unsupported parameter set");
   end

   logic [IDW-1:0]          rr_ptr;
   logic [IDW-1:0]          grant;
   logic                    found;
   logic                    credit_ok;
   logic                    hs;
   logic [LAT:0]            vld_pipe;
   logic [LAT:0][IDW-1:0]   id_pipe;
   logic [OW-1:0]           inflight;
   logic [WID-1:0]          mem_y  [DEPTH];
   logic [IDW-1:0]          mem_id [DEPTH];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [CW-1:0]           count;
   logic                    push;
   logic                    pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search starting at rr_ptr, wrapping.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(rr_ptr) + i) % NREQ;
         if (!found && req_valid[j]) begin
            found = 1'b1;
            grant = IDW'(j);
         end
      end
   end

   // Every valid tag is a result that will need a FIFO slot.
   always_comb begin
      inflight = '0;
      for (int k = 0; k <= LAT; k++) inflight = inflight + OW'(vld_pipe[k]);
      credit_ok = (inflight + OW'(count)) < OW'(DEPTH);
   end

   assign req_ready = (found && credit_ok && !rst) ? (NREQ'(1) << grant) : '0;
   assign hs        = |req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         cub_x    <= '0;
         cub_a0   <= '0;
         cub_a1   <= '0;
         cub_a2   <= '0;
         rr_ptr   <= '0;
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LAT-1:0], hs};
         id_pipe  <= {id_pipe[LAT-1:0], (hs ? grant : id_pipe[0])};
         if (hs) begin
            cub_x  <= req_x [int'(grant)*WID +: WID];
            cub_a0 <= req_a0[int'(grant)*WID +: WID];
            cub_a1 <= req_a1[int'(grant)*WID +: WID];
            cub_a2 <= req_a2[int'(grant)*WID +: WID];
            rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
         end
      end
   end

   // Tag reaching the last stage lines up with cub_y from the same issue.
   assign push = vld_pipe[LAT];
   assign pop  = (count != '0) && res_ready;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_y [wr_ptr] <= cub_y;
         mem_id[wr_ptr] <= id_pipe[LAT];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign res_valid = (count != '0);
   assign res_y     = res_valid ? mem_y [rd_ptr] : '0;
   assign res_id    = res_valid ? mem_id[rd_ptr] : '0;

`ifdef CUBIC_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (hs) stat_issued <= stat_issued + 32'd1;
         if (|req_valid && !credit_ok) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cubic_sched.sv
// Scoreboard bench for cubic_sched with a behavioural 2-stage cubic datapath stand-in.
module tb_cubic_sched;
   localparam int WID = 16, FBITS = 12, NREQ = 4, LAT = 2, DEPTH = 4, IDW = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid, req_ready;
   logic [NREQ*WID-1:0] req_x, req_a0, req_a1, req_a2;
   logic [WID-1:0]      cub_x, cub_a0, cub_a1, cub_a2, cub_y, res_y;
   logic                res_valid, res_ready;
   logic [IDW-1:0]      res_id;

   always #5 clk = ~clk;

   cubic_sched #(.WID(WID), .FBITS(FBITS), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_a0(req_a0), .req_a1(req_a1), .req_a2(req_a2),
      .cub_x(cub_x), .cub_a0(cub_a0), .cub_a1(cub_a1), .cub_a2(cub_a2), .cub_y(cub_y),
      .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id));

   // y = x^3 + a2*x^2 + a1*x + a0 in Q4.12, truncating and wrapping each step
   function automatic logic [15:0] cub(input logic [15:0] x, a0, a1, a2);
      logic signed [15:0] xs, s;
      logic signed [31:0] t;
      xs = x;
      s  = xs + $signed(a2);
      t  = s * xs;
      s  = t[FBITS +: 16];
      s  = s + $signed(a1);
      t  = s * xs;
      s  = t[FBITS +: 16];
      s  = s + $signed(a0);
      return s;
   endfunction

   logic [15:0] dp1, dp2;
   always @(posedge clk) begin
      if (rst) begin
         dp1 <= '0;
         dp2 <= '0;
      end else begin
         dp1 <= cub(cub_x, cub_a0, cub_a1, cub_a2);
         dp2 <= dp1;
      end
   end
   assign cub_y = dp2;

   typedef struct { logic [15:0] x, a0, a1, a2; } op_t;
   typedef struct { logic [15:0] y; int id; int rdy; } exp_t;

   op_t  pend [NREQ][$];
   exp_t sbq[$];
   int   issue_log[$];
   int   tests = 0, fails = 0, cyc = 0, outstanding = 0, rr = 0;
   int   last_id = -1;
   logic [15:0] last_y = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (pend[i].size() > 0) begin
            req_valid[i]           = 1'b1;
            req_x [i*WID +: WID]   = pend[i][0].x;
            req_a0[i*WID +: WID]   = pend[i][0].a0;
            req_a1[i*WID +: WID]   = pend[i][0].a1;
            req_a2[i*WID +: WID]   = pend[i][0].a2;
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   function automatic op_t rnd_op();
      op_t o;
      o.x  = 16'($urandom_range(0, 16'hffff));
      o.a0 = 16'($urandom_range(0, 16'hffff));
      o.a1 = 16'($urandom_range(0, 16'hffff));
      o.a2 = 16'($urandom_range(0, 16'hffff));
      return o;
   endfunction

   function automatic bit busy();
      for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) return 1'b1;
      return sbq.size() > 0;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (busy() && n < 400) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < 400), 32'd1);
   endtask

   // Reference model: round robin over live requests, DEPTH outstanding results max,
   // each result visible LAT+2 sampling points after its handshake, in issue order.
   logic [NREQ-1:0] exp_rdy;
   logic            exp_valid;
   int              g;
   exp_t            e;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         sbq.delete();
         outstanding = 0;
         rr = 0;
      end else begin
         g = -1;
         exp_rdy = '0;
         if (outstanding < DEPTH)
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         exp_valid = (sbq.size() > 0) && (sbq[0].rdy <= cyc);
         chk("res_valid", 32'(res_valid), 32'(exp_valid));
         if (g >= 0) begin
            e.y   = cub(req_x[g*WID +: WID], req_a0[g*WID +: WID],
                        req_a1[g*WID +: WID], req_a2[g*WID +: WID]);
            e.id  = g;
            e.rdy = cyc + LAT + 2;
            sbq.push_back(e);
            issue_log.push_back(g);
            void'(pend[g].pop_front());
            rr = (g + 1) % NREQ;
            outstanding++;
         end
         if (res_valid && res_ready) begin
            if (sbq.size() == 0) begin
               chk("res_spurious", 32'(res_valid), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("res_y", 32'(res_y), 32'(e.y));
               chk("res_id", 32'(res_id), 32'(e.id));
               last_y  = res_y;
               last_id = int'(res_id);
               outstanding--;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   mark, start, n;
      op_t  o;
      logic [15:0] ey;
      rst = 1'b1; res_ready = 1'b0; req_valid = '0;
      req_x = '0; req_a0 = '0; req_a1 = '0; req_a2 = '0;
      repeat (3) step();
      @(negedge clk); #1;
      chk("rst_cub_x", 32'(cub_x), 32'd0);
      chk("rst_cub_a", 32'(cub_a0 | cub_a1 | cub_a2), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_y", 32'(res_y), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      step();
      rst = 1'b0;
      step();

      // single request: 1.0^3 = 1.0
      res_ready = 1'b1;
      mark = issue_log.size();
      o = '{16'd4096, 16'd0, 16'd0, 16'd0};
      pend[0].push_back(o);
      drain();
      chk("single_issues", 32'(issue_log.size() - mark), 32'd1);
      chk("single_y", 32'(last_y), 32'd4096);
      chk("single_id", 32'(last_id), 32'd0);

      // all requesters valid: strict rotation
      mark = issue_log.size();
      start = (issue_log[mark-1] + 1) % NREQ;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < NREQ; i++) pend[i].push_back(rnd_op());
      drain();
      for (int k = 0; k < 3*NREQ; k++) chk("rr_order", 32'(issue_log[mark+k]), 32'((start + k) % NREQ));

      // credit limit with consumer stalled
      res_ready = 1'b0;
      mark = issue_log.size();
      for (int k = 0; k < 6; k++) pend[k % 3].push_back(rnd_op());
      repeat (12) step();
      chk("credit_issued", 32'(issue_log.size() - mark), 32'd4);
      chk("credit_ready_low", 32'(req_ready), 32'd0);
      res_ready = 1'b1;
      drain();
      chk("credit_total", 32'(issue_log.size() - mark), 32'd6);

      // full FIFO with pops trickling in while requests keep arriving
      res_ready = 1'b0;
      for (int k = 0; k < 8; k++) pend[k % NREQ].push_back(rnd_op());
      repeat (8) step();
      for (int k = 0; k < 6; k++) begin
         res_ready = (k % 2 == 0);
         step();
      end
      res_ready = 1'b1;
      drain();

      // reset with one result in the FIFO and two in flight
      res_ready = 1'b0;
      for (int i = 1; i < NREQ; i++) pend[i].push_back(rnd_op());
      n = 0;
      while (!res_valid && n < 20) begin
         step();
         n++;
      end
      chk("midrst_first_result", 32'(res_valid), 32'd1);
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) pend[i].delete();
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      repeat (6) step();
      chk("midrst_no_stale", 32'(res_valid), 32'd0);
      o = rnd_op();
      ey = cub(o.x, o.a0, o.a1, o.a2);
      pend[2].push_back(o);
      res_ready = 1'b1;
      drain();
      chk("midrst_next_y", 32'(last_y), 32'(ey));
      chk("midrst_next_id", 32'(last_id), 32'd2);

      // random traffic, random backpressure
      for (int c = 0; c < 400; c++) begin
         res_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) pend[$urandom_range(0, NREQ-1)].push_back(rnd_op());
         step();
      end
      res_ready = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
